// File: rtl/divider_controller_if.sv
// Configuration port bundle for divider_controller: valid/ready offer of a
// divide ratio and a tick budget.
interface divider_controller_if #(
    parameter int CNT_W   = 28,
    parameter int PULSE_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div;
    logic [PULSE_W-1:0] cfg_pulses;

    modport master (output cfg_valid, output cfg_div, output cfg_pulses, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, input cfg_pulses, output cfg_ready);
endinterface

// File: rtl/divider_controller.sv
// Programmable prescaler sequencer: one-cycle tick every div_r cycles, T-FF
// output, optional tick budget. Optional duty output under DIVCTRL_DUTY_EN.
module divider_controller #(
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 100000000,
    parameter int PULSE_W     = 16
) (
    input  logic clk,
    input  logic reset,
    divider_controller_if.slave cfg,
    input  logic start,
    input  logic stop,
    output logic tick,
    output logic toggle_q,
    output logic busy,
`ifdef DIVCTRL_DUTY_EN
    output logic clk_out,
`endif
    output logic done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    // Ratios below 2 cannot produce a distinct tick period, so they are raised to 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [PULSE_W-1:0] pulses_q, pulses_d;
    logic [PULSE_W-1:0] left_q, left_d;
    logic               tick_q, tick_d;
    logic               tog_q, tog_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               duty_q, duty_d;

    // Next-state, counter and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pulses_d = pulses_q;
        left_d   = left_q;
        tick_d   = 1'b0;
        tog_d    = tog_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg.cfg_valid) begin
                    div_d    = clamp_div(cfg.cfg_div);
                    pulses_d = cfg.cfg_pulses;
                end else begin
                    div_d    = div_q;
                    pulses_d = pulses_q;
                end
                // A config accepted this cycle is already the one the run uses.
                if (start && !stop) begin
                    state_d = RUN;
                    left_d  = pulses_d;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == div_q - CNT_W'(1)) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    tog_d  = ~tog_q;
                    if (pulses_q != '0) begin
                        left_d = left_q - PULSE_W'(1);
                        if (left_q == PULSE_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        left_d = left_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        duty_d = (state_d == RUN) && (cnt_d < (div_d >> 1));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= DEF_DIV;
            pulses_q <= '0;
            left_q   <= '0;
            tick_q   <= 1'b0;
            tog_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            duty_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pulses_q <= pulses_d;
            left_q   <= left_d;
            tick_q   <= tick_d;
            tog_q    <= tog_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            duty_q   <= duty_d;
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign tick          = tick_q;
    assign toggle_q      = tog_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef DIVCTRL_DUTY_EN
    assign clk_out       = duty_q;
`else
    logic unused_duty_s;
    assign unused_duty_s = duty_q;
`endif
endmodule

// File: tb/tb_divider_controller.sv
// Self-checking bench for divider_controller: directed scenarios plus a
// randomized phase, all checked against a cycle-count reference model.
module tb_divider_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic tick, toggle_q, busy, done;
`ifdef DIVCTRL_DUTY_EN
    logic clk_out;
`endif

    divider_controller_if #(.CNT_W(28), .PULSE_W(16)) cif ();

    divider_controller #(.CNT_W(28), .DEFAULT_DIV(100000000), .PULSE_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg      (cif),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .toggle_q (toggle_q),
        .busy     (busy),
`ifdef DIVCTRL_DUTY_EN
        .clk_out  (clk_out),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: cycles since start and ticks produced, modulo arithmetic.
    bit m_run, m_fin, m_tick, m_done, m_tog;
    int m_k, m_div, m_pulses, m_ticks;

    task automatic model_reset();
        m_run = 1'b0; m_fin = 1'b0; m_tick = 1'b0; m_done = 1'b0; m_tog = 1'b0;
        m_k = 0; m_div = 100000000; m_pulses = 0; m_ticks = 0;
    endtask

    task automatic model_edge();
        m_tick = 1'b0;
        m_done = 1'b0;
        if (m_fin) begin
            m_fin = 1'b0;
        end else if (!m_run) begin
            if (cif.cfg_valid) begin
                m_div    = (int'(cif.cfg_div) < 2) ? 2 : int'(cif.cfg_div);
                m_pulses = int'(cif.cfg_pulses);
            end
            if (start && !stop) begin
                m_run = 1'b1; m_k = 0; m_ticks = 0;
            end
        end else if (stop) begin
            m_run = 1'b0;
        end else begin
            m_k++;
            if (m_k % m_div == 0) begin
                m_tick = 1'b1;
                m_tog  = !m_tog;
                m_ticks++;
                if (m_pulses != 0 && m_ticks == m_pulses) begin
                    m_run = 1'b0; m_fin = 1'b1; m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input string name, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%0b expected=%0b", tag, name, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, "tick", tick, m_tick);
        chk(tag, "toggle_q", toggle_q, m_tog);
        chk(tag, "busy", busy, m_run);
        chk(tag, "done", done, m_done);
        chk(tag, "cfg_ready", cif.cfg_ready, !m_run && !m_fin);
`ifdef DIVCTRL_DUTY_EN
        chk(tag, "clk_out", clk_out, m_run && ((m_k % m_div) < (m_div / 2)));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input int d, input int p, input logic s, input logic sp);
        cif.cfg_valid  = v;
        cif.cfg_div    = 28'(d);
        cif.cfg_pulses = 16'(p);
        start = s;
        stop  = sp;
    endtask

    initial begin
        int tpos[$];
        int dpos;
        int hi;
        model_reset();
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #3;
        check_all("reset_init");
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted mid-run clears everything before any clock edge.
        drive(1'b1, 3, 0, 1'b1, 1'b0);
        step("t1_start");
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("t1_run");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("t1_reset_mid_run");
        @(negedge clk);
        reset = 1'b1;
        step("t1_after_reset");

        // div=4, 3 pulses: ticks 4,8,12 cycles after the start edge.
        drive(1'b1, 4, 3, 1'b1, 1'b0);
        step("t2_start");
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        dpos = -1;
        for (int i = 1; i <= 15; i++) begin
            step("t2_run");
            if (tick === 1'b1) tpos.push_back(i);
            if (done === 1'b1) dpos = i;
        end
        chk_int("t2_tick_count", tpos.size(), 3);
        if (tpos.size() == 3) begin
            chk_int("t2_tick1", tpos[0], 4);
            chk_int("t2_tick2", tpos[1], 8);
            chk_int("t2_tick3", tpos[2], 12);
        end
        chk_int("t2_done_cycle", dpos, 12);

        // Ratios 1 and 0 behave as 2.
        drive(1'b1, 1, 2, 1'b1, 1'b0);
        step("t3_div1_start");
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step("t3_div1");
        drive(1'b1, 0, 0, 1'b1, 1'b0);
        step("t3_div0_start");
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step("t3_div0");
        stop = 1'b1;
        step("t3_stop");
        stop = 1'b0;
        step("t3_idle");

        // div=6 continuous, stop while cnt==5: stop wins over the tick.
        model_reset();
        reset = 1'b0;
        #1;
        check_all("t4_reset");
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 6, 0, 1'b1, 1'b0);
        step("t4_start");
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 11; i++) step("t4_run");
        stop = 1'b1;
        step("t4_stop");
        chk("t4_direct", "tick", tick, 1'b0);
        chk("t4_direct", "toggle_q", toggle_q, 1'b1);
        chk("t4_direct", "cfg_ready", cif.cfg_ready, 1'b1);
        stop = 1'b0;
        step("t4_idle");

        // Config and start offered during RUN are ignored.
        drive(1'b1, 3, 0, 1'b1, 1'b0);
        step("t5_start");
        drive(1'b1, 7, 1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step("t5_run_cfg");
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        step("t5_stop");
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        step("t5_start_stop");
        chk("t5_direct", "busy", busy, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        step("t5_idle");

`ifdef DIVCTRL_DUTY_EN
        // div=5 continuous: 2 high, 3 low.
        drive(1'b1, 5, 0, 1'b1, 1'b0);
        step("t6_start");
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        hi = (clk_out === 1'b1) ? 1 : 0;
        for (int i = 1; i < 10; i++) begin
            step("t6_run");
            if (clk_out === 1'b1) hi++;
        end
        chk_int("t6_high_count", hi, 4);
        stop = 1'b1;
        step("t6_stop");
        stop = 1'b0;
`else
        hi = 0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) == 0), int'($urandom_range(7)), int'($urandom_range(3)),
                  ($urandom_range(2) == 0), ($urandom_range(15) == 0));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
